// File: rtl/rvnoob_div_pkg.sv
// Shared definitions for the RVNoob multi-cycle divider.
//   div_state_t    : sequencer states (IDLE, CALC, FIX, DONE)
//   DIV_BY_ZERO_Q  : quotient returned for a zero divisor (all ones)
//   div_most_neg() : most-negative two's-complement value of a given width,
//                    returned in a 64-bit container (bit w-1 set)
package rvnoob_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } div_state_t;

    localparam int          DIV_MAX_XLEN  = 64;
    localparam logic [63:0] DIV_BY_ZERO_Q = 64'hFFFF_FFFF_FFFF_FFFF;

    function automatic logic [63:0] div_most_neg(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/rvnoob_div_prep.sv
// Combinational operand preparation for the divider, evaluated in the accept
// cycle.
//   in_signed/in_word : operation family and word-variant select
//   src1/src2         : raw dividend/divisor from the register file
//   dividend          : dividend after word selection and sign/zero extension
//   dividend_abs      : magnitude of the (extended) dividend
//   divisor_abs       : magnitude of the (extended) divisor
//   dividend_neg      : dividend is negative (signed ops only)
//   divisor_neg       : divisor is negative (signed ops only)
//   div_zero          : divisor is zero over the operating width
//   overflow          : signed most-negative / -1 case
module rvnoob_div_prep
    import rvnoob_div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            in_signed,
    input  logic            in_word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic [XLEN-1:0] dividend,
    output logic [XLEN-1:0] dividend_abs,
    output logic [XLEN-1:0] divisor_abs,
    output logic            dividend_neg,
    output logic            divisor_neg,
    output logic            div_zero,
    output logic            overflow
);

    logic [XLEN-1:0] op_raw [2];
    logic [XLEN-1:0] op_ext [2];
    logic [XLEN-1:0] op_abs [2];
    logic            op_neg [2];
    logic [63:0]     most_neg;

    assign op_raw[0] = src1;
    assign op_raw[1] = src2;

    // Both operands go through identical extension / magnitude logic.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_op
            assign op_ext[gi] = in_word
                ? {{(XLEN-32){in_signed & op_raw[gi][31]}}, op_raw[gi][31:0]}
                : op_raw[gi];
            assign op_neg[gi] = in_signed & op_ext[gi][XLEN-1];
            // Most-negative input maps to 2^(W-1), which is still exact as
            // an unsigned magnitude.
            assign op_abs[gi] = op_neg[gi] ? -op_ext[gi] : op_ext[gi];
        end
    endgenerate

    assign most_neg = div_most_neg(in_word ? 32'd32 : 32'(XLEN));

    assign dividend     = op_ext[0];
    assign dividend_abs = op_abs[0];
    assign divisor_abs  = op_abs[1];
    assign dividend_neg = op_neg[0];
    assign divisor_neg  = op_neg[1];
    assign div_zero     = (op_ext[1] == '0);

    always_comb begin
        overflow = 1'b0;
        if (in_signed) begin
            if (in_word)
                overflow = (op_ext[0][31:0] == most_neg[31:0]) && (op_ext[1][31:0] == 32'hFFFF_FFFF);
            else
                overflow = (op_ext[0] == most_neg[XLEN-1:0]) && (op_ext[1] == '1);
        end
    end

endmodule

// File: rtl/rvnoob_div_seq.sv
// Multi-cycle RV64M divide/remainder unit (DIV/DIVU/REM/REMU and *W forms).
// Radix-2 restoring division, one quotient bit per cycle; divide-by-zero and
// signed overflow resolve straight to DONE.
//   clk, reset           : clock, synchronous active-high reset
//   flush                : kill in-flight op, back to IDLE next cycle
//   in_valid/in_ready    : request handshake (in_ready only in IDLE)
//   in_signed, in_word   : op family, word variant
//   src1, src2           : dividend, divisor
//   out_valid/out_ready  : result handshake (result held until accepted)
//   quotient, remainder  : results, sign-extended from bit 31 for word ops
module rvnoob_div_seq
    import rvnoob_div_pkg::*;
#(
    parameter int XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic            in_signed,
    input  logic            in_word,
    input  logic [XLEN-1:0] src1,
    input  logic [XLEN-1:0] src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] quotient,
    output logic [XLEN-1:0] remainder
);

    localparam int CW = $clog2(XLEN);

    div_state_t      state_reg, state_next;
    logic [CW-1:0]   cnt_reg, cnt_next;
    logic [XLEN-1:0] rem_reg, rem_next;
    logic [XLEN-1:0] quo_reg, quo_next;
    logic [XLEN-1:0] dvs_reg, dvs_next;
    logic            q_neg_reg, q_neg_next;
    logic            r_neg_reg, r_neg_next;
    logic            word_reg, word_next;
    logic [XLEN-1:0] quotient_reg, quotient_next;
    logic [XLEN-1:0] remainder_reg, remainder_next;

    logic [XLEN-1:0] dividend, dividend_abs, divisor_abs;
    logic            dividend_neg, divisor_neg, div_zero, overflow;

    // Shifted partial remainder needs one extra bit: an unsigned divisor
    // near 2^XLEN leaves a remainder whose shift overflows XLEN bits.
    logic [XLEN:0]   shifted;
    logic [XLEN:0]   trial;

    rvnoob_div_prep #(.XLEN(XLEN)) u_prep (
        .in_signed    (in_signed),
        .in_word      (in_word),
        .src1         (src1),
        .src2         (src2),
        .dividend     (dividend),
        .dividend_abs (dividend_abs),
        .divisor_abs  (divisor_abs),
        .dividend_neg (dividend_neg),
        .divisor_neg  (divisor_neg),
        .div_zero     (div_zero),
        .overflow     (overflow)
    );

    function automatic logic [XLEN-1:0] fit_word(input logic w, input logic [XLEN-1:0] v);
        return w ? {{(XLEN-32){v[31]}}, v[31:0]} : v;
    endfunction

    assign shifted = {rem_reg, quo_reg[XLEN-1]};
    assign trial   = shifted - {1'b0, dvs_reg};

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            rem_reg       <= '0;
            quo_reg       <= '0;
            dvs_reg       <= '0;
            q_neg_reg     <= 1'b0;
            r_neg_reg     <= 1'b0;
            word_reg      <= 1'b0;
            quotient_reg  <= '0;
            remainder_reg <= '0;
        end else begin
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            rem_reg       <= rem_next;
            quo_reg       <= quo_next;
            dvs_reg       <= dvs_next;
            q_neg_reg     <= q_neg_next;
            r_neg_reg     <= r_neg_next;
            word_reg      <= word_next;
            quotient_reg  <= quotient_next;
            remainder_reg <= remainder_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        cnt_next       = cnt_reg;
        rem_next       = rem_reg;
        quo_next       = quo_reg;
        dvs_next       = dvs_reg;
        q_neg_next     = q_neg_reg;
        r_neg_next     = r_neg_reg;
        word_next      = word_reg;
        quotient_next  = quotient_reg;
        remainder_next = remainder_reg;

        unique case (state_reg)
            IDLE: begin
                if (in_valid) begin
                    word_next  = in_word;
                    q_neg_next = dividend_neg ^ divisor_neg;
                    r_neg_next = dividend_neg;
                    if (div_zero) begin
                        quotient_next  = DIV_BY_ZERO_Q[XLEN-1:0];
                        remainder_next = fit_word(in_word, dividend);
                        state_next     = DONE;
                    end else if (overflow) begin
                        quotient_next  = fit_word(in_word, dividend);
                        remainder_next = '0;
                        state_next     = DONE;
                    end else begin
                        rem_next   = '0;
                        // Word dividends are left-aligned so the quotient
                        // ends up in the low 32 bits after 32 shifts.
                        quo_next   = in_word ? {dividend_abs[31:0], {(XLEN-32){1'b0}}} : dividend_abs;
                        dvs_next   = divisor_abs;
                        cnt_next   = in_word ? CW'(31) : CW'(XLEN-1);
                        state_next = CALC;
                    end
                end
            end
            CALC: begin
                quo_next = {quo_reg[XLEN-2:0], ~trial[XLEN]};
                rem_next = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
                cnt_next = cnt_reg - 1'b1;
                if (cnt_reg == '0)
                    state_next = FIX;
            end
            FIX: begin
                quotient_next  = fit_word(word_reg, q_neg_reg ? -quo_reg : quo_reg);
                remainder_next = fit_word(word_reg, r_neg_reg ? -rem_reg : rem_reg);
                state_next     = DONE;
            end
            DONE: begin
                if (out_ready) begin
                    state_next     = IDLE;
                    quotient_next  = '0;
                    remainder_next = '0;
                end
            end
            default: state_next = IDLE;
        endcase

        // Redirect/trap kill: drop everything, including a pending result.
        if (flush) begin
            state_next     = IDLE;
            cnt_next       = '0;
            rem_next       = '0;
            quo_next       = '0;
            dvs_next       = '0;
            q_neg_next     = 1'b0;
            r_neg_next     = 1'b0;
            word_next      = 1'b0;
            quotient_next  = '0;
            remainder_next = '0;
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);
    assign quotient  = quotient_reg;
    assign remainder = remainder_reg;

endmodule

// File: tb/tb_rvnoob_div_seq.sv
// Directed self-checking bench for rvnoob_div_seq.
module tb_rvnoob_div_seq;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic        in_signed;
    logic        in_word;
    logic [63:0] src1;
    logic [63:0] src2;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] quotient;
    logic [63:0] remainder;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    rvnoob_div_seq #(.XLEN(64)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_signed (in_signed),
        .in_word   (in_word),
        .src1      (src1),
        .src2      (src2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .quotient  (quotient),
        .remainder (remainder)
    );

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // Present one request; returns at #1 after the accepting edge (cycle 1).
    // Operands are scrambled afterwards to prove they were latched.
    task automatic start_op(input logic sg, input logic wd, input logic [63:0] a, input logic [63:0] b);
        chk("idle_ready", {63'd0, in_ready}, 64'd1);
        in_valid  = 1'b1;
        in_signed = sg;
        in_word   = wd;
        src1      = a;
        src2      = b;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        src1     = {$urandom, $urandom};
        src2     = {$urandom, $urandom};
    endtask

    // Counts cycles from accept until out_valid, bounded.
    task automatic wait_valid(output int lat);
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
        end
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("post_hs_ready", {63'd0, in_ready}, 64'd1);
        chk("post_hs_valid", {63'd0, out_valid}, 64'd0);
    endtask

    task automatic run_op(input string tag, input logic sg, input logic wd,
                          input logic [63:0] a, input logic [63:0] b,
                          input logic [63:0] eq, input logic [63:0] er, input int elat);
        int lat;
        start_op(sg, wd, a, b);
        if (elat > 1)
            chk({tag, "_busy"}, {63'd0, in_ready}, 64'd0);
        wait_valid(lat);
        chk({tag, "_lat"}, 64'(lat), 64'(elat));
        chk({tag, "_q"}, quotient, eq);
        chk({tag, "_r"}, remainder, er);
        $display("op %s: q=%h r=%h lat=%0d", tag, quotient, remainder, lat);
        handshake();
    endtask

    initial begin
        int lat;
        int bad;
        logic [63:0] q_hold;
        logic [63:0] r_hold;

        reset     = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_signed = 1'b0;
        in_word   = 1'b0;
        src1      = '0;
        src2      = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        chk("rst_ready", {63'd0, in_ready}, 64'd1);
        chk("rst_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_q", quotient, 64'd0);
        chk("rst_r", remainder, 64'd0);

        // Directed vectors
        run_op("divu_100_7", 1'b0, 1'b0, 64'd100, 64'd7, 64'd14, 64'd2, 66);
        run_op("div_m7_2", 1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
               64'hFFFF_FFFF_FFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFFF, 66);
        run_op("div_7_m2", 1'b1, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFE,
               64'hFFFF_FFFF_FFFF_FFFD, 64'd1, 66);
        run_op("div0_s", 1'b1, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1);
        run_op("div0_u", 1'b0, 1'b0, 64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 1);
        run_op("ovf_x", 1'b1, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 64'd0, 1);
        run_op("ovf_w", 1'b1, 1'b1, 64'h0000_0000_8000_0000, 64'h0000_0000_FFFF_FFFF,
               64'hFFFF_FFFF_8000_0000, 64'd0, 1);
        run_op("divuw", 1'b0, 1'b1, 64'hDEAD_0000_FFFF_FFFF, 64'd2,
               64'h0000_0000_7FFF_FFFF, 64'd1, 34);
        run_op("remw_m7_3", 1'b1, 1'b1, 64'h1234_0000_FFFF_FFF9, 64'hAAAA_0000_0000_0003,
               64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF, 34);
        run_op("divuw_sext", 1'b0, 1'b1, 64'h0000_0000_8000_0000, 64'd1,
               64'hFFFF_FFFF_8000_0000, 64'd0, 34);
        run_op("divu_max", 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'd1, 64'd0, 66);

        // Flush at cycle 20 of a DIVU
        start_op(1'b0, 1'b0, 64'd1000, 64'd3);
        repeat (19) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        chk("flush_ready", {63'd0, in_ready}, 64'd1);
        chk("flush_valid", {63'd0, out_valid}, 64'd0);
        chk("flush_q", quotient, 64'd0);
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (out_valid) bad++;
        end
        chk("flush_no_valid", 64'(bad), 64'd0);
        $display("op flush_mid_calc: valid_after_flush=%0d", bad);

        // Hold out_ready low for 10 cycles in DONE
        start_op(1'b0, 1'b0, 64'd100, 64'd7);
        wait_valid(lat);
        chk("hold_lat", 64'(lat), 64'd66);
        q_hold = quotient;
        r_hold = remainder;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (!out_valid || in_ready || quotient !== q_hold || remainder !== r_hold) bad++;
        end
        chk("hold_stable", 64'(bad), 64'd0);
        chk("hold_q", quotient, 64'd14);
        chk("hold_r", remainder, 64'd2);
        chk("hold_ready_low", {63'd0, in_ready}, 64'd0);
        $display("op hold_done: q=%h r=%h unstable=%0d", quotient, remainder, bad);
        handshake();

        // flush and out_ready together in DONE: flush wins
        start_op(1'b1, 1'b0, 64'd9, 64'd0);
        wait_valid(lat);
        chk("fo_lat", 64'(lat), 64'd1);
        flush     = 1'b1;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        flush     = 1'b0;
        out_ready = 1'b0;
        chk("fo_ready", {63'd0, in_ready}, 64'd1);
        chk("fo_valid", {63'd0, out_valid}, 64'd0);
        chk("fo_q", quotient, 64'd0);
        chk("fo_r", remainder, 64'd0);
        $display("op flush_with_ready: in_ready=%0d out_valid=%0d", in_ready, out_valid);

        // Reset mid-CALC
        start_op(1'b0, 1'b0, 64'd12345, 64'd11);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("rst2_ready", {63'd0, in_ready}, 64'd1);
        chk("rst2_valid", {63'd0, out_valid}, 64'd0);
        chk("rst2_q", quotient, 64'd0);
        chk("rst2_r", remainder, 64'd0);
        $display("op reset_mid_calc: in_ready=%0d out_valid=%0d", in_ready, out_valid);

        // Recovery after reset: 12345 / 11 = 1122 rem 3
        run_op("post_rst", 1'b0, 1'b0, 64'd12345, 64'd11, 64'd1122, 64'd3, 66);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rvnoob_div_seq.md
Name: rvnoob_div_seq

Overview:
- Multi-cycle sequencer and datapath for the RV64M divide/remainder group in the RVNoob core: DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW.
- Sits beside the single-cycle ALU in EXU. EXU issues one operation with a valid/ready handshake and stalls until the result handshake completes.
- Radix-2 restoring iteration, one quotient bit per cycle.
- RISC-V divide-by-zero and signed-overflow results are resolved without iterating.

Parameters:
- XLEN, 64, architectural register width. Word ops always use 32.

Ports:
- clk  in  1  core clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  kill the in-flight operation (redirect/trap); highest priority after reset
- in_valid  in  1  operation request
- in_ready  out  1  block can accept; high only in IDLE
- in_signed  in  1  1 = DIV/REM family, 0 = DIVU/REMU family
- in_word  in  1  1 = *W variant, operates on src[31:0]
- src1  in  XLEN  dividend
- src2  in  XLEN  divisor
- out_valid  out  1  result valid; held until out_ready
- out_ready  in  1  consumer accepts result
- quotient  out  XLEN  quotient, sign-extended from bit 31 when in_word
- remainder  out  XLEN  remainder, sign-extended from bit 31 when in_word

Behaviour:
- States: IDLE, CALC, FIX, DONE.
- Reset, or flush in any state -> IDLE next cycle. Outputs then: in_ready=1, out_valid=0, quotient=0, remainder=0; internal registers cleared.
- Operand prep, combinational at accept. Word op: signed uses sign-extended src[31:0]; unsigned uses zero-extended src[31:0]. Width W = 32 if in_word, else XLEN.
- Signed op: work on absolute values. Latch q_neg = sign(a) XOR sign(b) and r_neg = sign(a).
- Accept = in_valid && in_ready, in IDLE (cycle 0). Transitions from IDLE:
  - Divisor (W bits) == 0 -> DONE. quotient = all ones; remainder = dividend.
  - Signed, dividend == most-negative W-bit value, and divisor == -1 -> DONE. quotient = dividend; remainder = 0.
  - Otherwise -> CALC with counter = W-1 and partial remainder = 0.
- Special cases raise out_valid at cycle 1.
- CALC, per cycle:
  - Shift {rem, quo} left one bit.
  - Trial-subtract |divisor|; if no borrow, keep the difference and set the quotient LSB.
  - Counter decrements; at counter 0 -> FIX.
- FIX: apply negation per q_neg/r_neg, sign-extend bit 31 for word ops, register results -> DONE.
- Normal latency: out_valid first high at cycle W+2 (66 for XLEN ops, 34 for W ops).
- DONE: out_valid=1; quotient/remainder stable while waiting. out_valid && out_ready -> IDLE next cycle, so in_ready returns one cycle after the result handshake (no same-cycle re-accept).
- in_valid ignored outside IDLE; operands are latched at accept, so src changes afterwards have no effect.
- flush and out_ready in the same cycle: flush wins, result discarded, IDLE next.
- Remainder sign always follows the dividend; quotient truncates toward zero.

Decomposition:
- Shared package rvnoob_div_pkg:
  - state enum typedef
  - constant DIV_BY_ZERO_Q (all ones)
  - function for most-negative value by width
- One sub-module, rvnoob_div_prep (combinational): word selection, sign/zero extension, absolute values, special-case detection. The sequencer owns the FSM, counter and shift registers.

Test Plan:
- DIVU/REMU, src1=100, src2=7 -> quotient=14, remainder=2; out_valid rises exactly at cycle 66.
- DIV/REM, src1=-7, src2=2 -> quotient=0xFFFFFFFFFFFFFFFD, remainder=0xFFFFFFFFFFFFFFFF.
- Divide by zero, src1=5, src2=0, signed and unsigned -> quotient=0xFFFFFFFFFFFFFFFF, remainder=5; out_valid at cycle 1.
- Overflow:
  - XLEN: src1=0x8000000000000000, src2=-1, signed -> quotient=0x8000000000000000, remainder=0.
  - DIVW: src1=0x0000000080000000, src2=0xFFFFFFFF -> quotient=0xFFFFFFFF80000000, remainder=0.
- DIVUW/REMUW, src1=0xDEAD0000FFFFFFFF, src2=2 -> quotient=0x000000007FFFFFFF, remainder=1; out_valid at cycle 34. Upper src bits must be ignored.
- Control cases:
  - Assert flush at cycle 20 of a DIVU -> IDLE next cycle, out_valid never rises.
  - Hold out_ready=0 for 10 cycles in DONE -> result stable, in_ready low; in_ready=1 on the cycle after out_ready.
  - reset mid-CALC -> all outputs at reset values.
